// File: rtl/ds1302_pkg.sv
// Shared constants for the DS1302 read sequencer: register count, the
// read-command byte for each timekeeping register, and the FSM state type.
package ds1302_pkg;

  localparam int NUM_RD_REGS = 7;

  // Read command bytes for sec, min, hour, date, month, day, year.
  localparam logic [7:0] RD_CMD [NUM_RD_REGS] = '{
    8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8B, 8'h8D
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/ds1302_poll_timer.sv
// Free-running poll timer for the DS1302 sequencer; tick is high for the
// one cycle in which the count sits at POLL_CYCLES-1, then it wraps to 0.
module ds1302_poll_timer #(
  parameter int POLL_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  output logic tick
);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  always_comb begin
    if (cnt_q == 24'(POLL_CYCLES - 1)) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 24'(POLL_CYCLES - 1));

endmodule

// File: rtl/ds1302_rd_seq.sv
// DS1302 read sequencer: sweeps the seven timekeeping registers through the
// single-register reader and commits a coherent BCD snapshot. Optional macro
// DS1302_CH_FLAG_EN exposes the clock-halt bit as rtc_halted and masks sec[7].
module ds1302_rd_seq
  import ds1302_pkg::*;
#(
  parameter int POLL_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rd_req,
  output logic       rd_start_flag,
  output logic [7:0] control_data,
  input  logic [7:0] reg_data,
  input  logic       rd_done,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] year,
  output logic       time_valid,
  output logic       busy,
  output logic       rd_err,
`ifdef DS1302_CH_FLAG_EN
  output logic       rtc_halted,
`endif
  output logic       err_flag
);

  logic tick;

  ds1302_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .sys_clk(sys_clk),
    .rst    (rst),
    .tick   (tick)
  );

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  shadow_q [NUM_RD_REGS];
  logic [7:0]  shadow_d [NUM_RD_REGS];
  logic [7:0]  time_q   [NUM_RD_REGS];
  logic [7:0]  time_d   [NUM_RD_REGS];
  logic [7:0]  ctrl_q, ctrl_d;
  logic        start_q, start_d;
  logic        tv_q, tv_d;
  logic        rderr_q, rderr_d;
  logic        errf_q, errf_d;
  logic        busy_q, busy_d;
`ifdef DS1302_CH_FLAG_EN
  logic        halted_q, halted_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    shadow_d = shadow_q;
    time_d   = time_q;
    tv_d     = 1'b0;
    rderr_d  = 1'b0;
    errf_d   = errf_q;
`ifdef DS1302_CH_FLAG_EN
    halted_d = halted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick || rd_req) begin
          idx_d   = 3'd0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        to_cnt_d = 16'd0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A done pulse on the last allowed cycle still counts as success.
        if (rd_done) begin
          shadow_d[idx_q] = reg_data;
          if (idx_q == 3'(NUM_RD_REGS - 1)) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rderr_d = 1'b1;
          errf_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_COMMIT: begin
        time_d  = shadow_q;
        tv_d    = 1'b1;
        errf_d  = 1'b0;
`ifdef DS1302_CH_FLAG_EN
        halted_d = shadow_q[0][7];
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start pulse and command byte are registered so they line up with ISSUE.
    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_ISSUE) begin
      ctrl_d = RD_CMD[idx_d];
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      to_cnt_q <= 16'd0;
      shadow_q <= '{default: 8'h00};
      time_q   <= '{default: 8'h00};
      ctrl_q   <= 8'h00;
      start_q  <= 1'b0;
      tv_q     <= 1'b0;
      rderr_q  <= 1'b0;
      errf_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DS1302_CH_FLAG_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      shadow_q <= shadow_d;
      time_q   <= time_d;
      ctrl_q   <= ctrl_d;
      start_q  <= start_d;
      tv_q     <= tv_d;
      rderr_q  <= rderr_d;
      errf_q   <= errf_d;
      busy_q   <= busy_d;
`ifdef DS1302_CH_FLAG_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign rd_start_flag = start_q;
  assign control_data  = ctrl_q;
  assign time_valid    = tv_q;
  assign rd_err        = rderr_q;
  assign err_flag      = errf_q;
  assign busy          = busy_q;
`ifdef DS1302_CH_FLAG_EN
  assign rtc_halted    = halted_q;
  assign sec           = {1'b0, time_q[0][6:0]};
`else
  assign sec           = time_q[0];
`endif
  assign min   = time_q[1];
  assign hour  = time_q[2];
  assign date  = time_q[3];
  assign month = time_q[4];
  assign day   = time_q[5];
  assign year  = time_q[6];

endmodule

// File: tb/tb_ds1302_rd_seq.sv
// Directed bench for ds1302_rd_seq with a fixed-latency reader model (L=47).
// Honours DS1302_CH_FLAG_EN when defined.
module tb_ds1302_rd_seq;

  localparam int L = 47;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic       rd_start_flag;
  logic [7:0] control_data;
  logic [7:0] reg_data = 8'h00;
  logic       rd_done = 1'b0;
  logic [7:0] sec, min, hour, date, month, day, year;
  logic       time_valid, busy, rd_err, err_flag;
`ifdef DS1302_CH_FLAG_EN
  logic       rtc_halted;
`endif

  ds1302_rd_seq #(
    .POLL_CYCLES   (1000),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_start_flag(rd_start_flag),
    .control_data (control_data),
    .reg_data     (reg_data),
    .rd_done      (rd_done),
    .sec          (sec),
    .min          (min),
    .hour         (hour),
    .date         (date),
    .month        (month),
    .day          (day),
    .year         (year),
    .time_valid   (time_valid),
    .busy         (busy),
    .rd_err       (rd_err),
`ifdef DS1302_CH_FLAG_EN
    .rtc_halted   (rtc_halted),
`endif
    .err_flag     (err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_bad = 0;
  int ecnt  = 0;
  int rel   = 0;
  int tvc   = 0;
  int log_cyc [$];
  logic [7:0] log_cmd [$];

  logic [7:0] rdat [7];
  logic       withhold = 1'b0;
  logic       rd_pend  = 1'b0;
  int         rd_left  = 0;
  logic [7:0] rd_cmd   = 8'h00;

  always @(posedge sys_clk) ecnt <= ecnt + 1;

  function automatic int cyc();
    return ecnt - rel;
  endfunction

  // Reader model: rd_done arrives L cycles after the start pulse; withholds the 0x87 read on demand.
  always begin
    @(posedge sys_clk);
    #1;
    rd_done = 1'b0;
    if (rd_pend) begin
      rd_left = rd_left - 1;
      if (rd_left == 0) begin
        rd_pend = 1'b0;
        if (!(withhold && rd_cmd == 8'h87)) begin
          rd_done  = 1'b1;
          reg_data = rdat[(int'(rd_cmd) - 129) / 2];
        end
      end
    end
    if (rd_start_flag === 1'b1) begin
      rd_pend = 1'b1;
      rd_left = L;
      rd_cmd  = control_data;
    end
  end

  always @(negedge sys_clk) begin
    if (rd_start_flag === 1'b1) begin
      log_cyc.push_back(cyc());
      log_cmd.push_back(control_data);
    end
    if (time_valid === 1'b1) tvc <= tvc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [55:0] v);
    for (int i = 0; i < 7; i++) rdat[i] = v[55 - 8*i -: 8];
  endtask

  task automatic chk_time(input string tag, input logic [55:0] e);
    logic [7:0] exp_sec;
`ifdef DS1302_CH_FLAG_EN
    exp_sec = {1'b0, e[54:48]};
`else
    exp_sec = e[55:48];
`endif
    chk({tag, ".sec"},   {24'd0, sec},   {24'd0, exp_sec});
    chk({tag, ".min"},   {24'd0, min},   {24'd0, e[47:40]});
    chk({tag, ".hour"},  {24'd0, hour},  {24'd0, e[39:32]});
    chk({tag, ".date"},  {24'd0, date},  {24'd0, e[31:24]});
    chk({tag, ".month"}, {24'd0, month}, {24'd0, e[23:16]});
    chk({tag, ".day"},   {24'd0, day},   {24'd0, e[15:8]});
    chk({tag, ".year"},  {24'd0, year},  {24'd0, e[7:0]});
  endtask

  task automatic chk_reset(input string tag);
    chk_time(tag, 56'h0);
    chk({tag, ".ctrl"},  {24'd0, control_data}, 32'h00);
    chk({tag, ".start"}, {31'd0, rd_start_flag}, 32'd0);
    chk({tag, ".tv"},    {31'd0, time_valid}, 32'd0);
    chk({tag, ".rderr"}, {31'd0, rd_err}, 32'd0);
    chk({tag, ".errf"},  {31'd0, err_flag}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy}, 32'd0);
`ifdef DS1302_CH_FLAG_EN
    chk({tag, ".halt"},  {31'd0, rtc_halted}, 32'd0);
`endif
  endtask

  task automatic go_to(input int n);
    while (cyc() < n) @(negedge sys_clk);
  endtask

  // which: 0 = time_valid, 1 = rd_err; at = cycle of the pulse or -1 on expiry.
  task automatic wait_for(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if ((which == 0 && time_valid === 1'b1) || (which == 1 && rd_err === 1'b1)) begin
        at = cyc();
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic pulse_req();
    rd_req = 1'b1;
    @(negedge sys_clk);
    rd_req = 1'b0;
  endtask

  localparam logic [55:0] DA = 56'h30_59_23_31_12_07_24;
  localparam logic [55:0] DB = 56'h45_10_08_15_06_03_25;
  localparam logic [55:0] DC = 56'h11_22_13_14_05_06_26;
  localparam logic [55:0] DD = 56'h85_00_12_01_01_01_00;

  initial begin
    int at;
    int snap;
    rst    = 1'b1;
    rd_req = 1'b0;
    load(DA);
    repeat (3) @(negedge sys_clk);
    chk_reset("rst0");
    rst = 1'b0;
    rel = ecnt;

    // Manual sweep: time_valid 338 cycles after the trigger cycle.
    go_to(5);
    pulse_req();
    chk("req.busy", {31'd0, busy}, 32'd1);
    wait_for(0, 600, at);
    chk("req.lat", at, 32'd343);
    chk_time("req", DA);
    chk("req.errf", {31'd0, err_flag}, 32'd0);
    chk("req.busy_end", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    chk("req.tv_pulse", {31'd0, time_valid}, 32'd0);

    // Poll sweeps triggered at 999, 1999, 2999.
    go_to(500);
    log_cyc.delete();
    log_cmd.delete();
    go_to(3400);
    chk("poll.n", log_cyc.size(), 32'd21);
    for (int i = 0; i < log_cyc.size() && i < 21; i++) begin
      chk($sformatf("poll.cyc%0d", i), log_cyc[i], 1000 * (i / 7 + 1) + (i % 7) * 48);
      chk($sformatf("poll.cmd%0d", i), {24'd0, log_cmd[i]}, 32'h81 + 2 * (i % 7));
    end

    // Timeout on the 4th read.
    load(DC);
    withhold = 1'b1;
    pulse_req();
    wait_for(1, 600, at);
    chk("to.lat", at, 32'd3801);
    chk("to.errf", {31'd0, err_flag}, 32'd1);
    chk("to.busy", {31'd0, busy}, 32'd0);
    chk_time("to.keep", DA);
    @(negedge sys_clk);
    chk("to.pulse", {31'd0, rd_err}, 32'd0);
    chk("to.sticky", {31'd0, err_flag}, 32'd1);
    withhold = 1'b0;
    load(DB);
    wait_for(0, 700, at);
    chk("to.recover_lat", at, 32'd4337);
    chk("to.errf_clr", {31'd0, err_flag}, 32'd0);
    chk_time("to.recover", DB);

    // Tick coincident with rd_req, request held 5 cycles: one sweep only.
    load(DA);
    go_to(4990);
    log_cyc.delete();
    log_cmd.delete();
    snap = tvc;
    go_to(4999);
    rd_req = 1'b1;
    go_to(5004);
    rd_req = 1'b0;
    go_to(5400);
    chk("one.n", log_cyc.size(), 32'd7);
    if (log_cyc.size() > 0) chk("one.first", log_cyc[0], 32'd5000);
    chk("one.tv", tvc - snap, 32'd1);
    chk_time("one", DA);

    // Reset during the 5th WAIT.
    load(DD);
    go_to(5500);
    pulse_req();
    go_to(5700);
    chk("rst.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge sys_clk);
    chk_reset("rst1");
    rst = 1'b0;
    rel = ecnt;
    log_cyc.delete();
    log_cmd.delete();
    snap = tvc;
    go_to(299);
    chk("rst.no_tv", tvc - snap, 32'd0);
    chk("rst.no_start", log_cyc.size(), 32'd0);
    go_to(300);
    pulse_req();
    wait_for(0, 600, at);
    chk("rst.relat", at, 32'd638);
    if (log_cmd.size() > 0) begin
      chk("rst.first_cmd", {24'd0, log_cmd[0]}, 32'h81);
      chk("rst.first_cyc", log_cyc[0], 32'd301);
    end else begin
      chk("rst.first_present", log_cmd.size(), 32'd1);
    end
    chk_time("ch", DD);
`ifdef DS1302_CH_FLAG_EN
    chk("ch.halt", {31'd0, rtc_halted}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
